// File: rtl/maze_legal_move_engine_pkg.sv
// Shared definitions for the maze legal-move engine.
// Direction bit indices, heading codes, FSM states and default maze geometry.
package maze_legal_move_engine_pkg;

    // Bit positions inside a heading or move mask: {down,up,right,left}
    localparam int DIR_L = 0;
    localparam int DIR_R = 1;
    localparam int DIR_U = 2;
    localparam int DIR_D = 3;

    // One-hot heading codes; any other code applies no look-ahead
    localparam logic [3:0] HEAD_L = 4'(1 << DIR_L);
    localparam logic [3:0] HEAD_R = 4'(1 << DIR_R);
    localparam logic [3:0] HEAD_U = 4'(1 << DIR_U);
    localparam logic [3:0] HEAD_D = 4'(1 << DIR_D);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_LOOK = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Default maze geometry
    localparam int DEF_N_CH    = 4;
    localparam int DEF_XW      = 10;
    localparam int DEF_COLS    = 8;
    localparam int DEF_ROWS    = 8;
    localparam int DEF_TILE_W  = 60;
    localparam int DEF_ORG_X   = 150;
    localparam int DEF_ORG_Y   = 34;
    localparam int DEF_LOOK_PX = 10;

endpackage

// File: rtl/maze_legal_move_engine_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// Ports: clk, rst (sync, active high), req[N_CH], accept (advance pointer),
//        grant[N_CH] one-hot, gidx = index of the granted channel.
module maze_legal_move_engine_rr_arbiter
    import maze_legal_move_engine_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            accept,
    output logic [N_CH-1:0] grant,
    output logic [CW-1:0]   gidx
);

    logic [CW-1:0] ptr;
    logic          found;

    always_comb begin : pick
        int c;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < N_CH; i++) begin
            c = (int'(ptr) + i) % N_CH;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                gidx     = CW'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (int'(gidx) == N_CH - 1) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/maze_legal_move_engine.sv
// Shared legal-move lookup for maze actors: arbitrate, look ahead along the
// heading, divide pixels into tiles, read a writable grid of move masks.
// Ports: clk, rst (sync, active high)
//   req_valid/req_ready[N_CH], req_xpos/req_ypos[N_CH*XW], req_dir[N_CH*4]
//   rsp_valid/rsp_ready, rsp_ch, rsp_moves {D,U,R,L}, rsp_oob
//   cfg_we/cfg_addr/cfg_data : grid write port (index row*COLS+col)
module maze_legal_move_engine
    import maze_legal_move_engine_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int XW      = DEF_XW,
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int TILE_W  = DEF_TILE_W,
    parameter int ORG_X   = DEF_ORG_X,
    parameter int ORG_Y   = DEF_ORG_Y,
    parameter int LOOK_PX = DEF_LOOK_PX,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AW = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    req_valid,
    output logic [N_CH-1:0]    req_ready,
    input  logic [N_CH*XW-1:0] req_xpos,
    input  logic [N_CH*XW-1:0] req_ypos,
    input  logic [N_CH*4-1:0]  req_dir,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [CW-1:0]      rsp_ch,
    output logic [3:0]         rsp_moves,
    output logic               rsp_oob,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [3:0]         cfg_data
);

    // Two spare bits: one for the look-ahead overshoot, one for sign
    localparam int SW  = XW + 2;
    localparam int RW  = XW + 1;
    localparam int NT  = COLS * ROWS;
    localparam int QXW = $clog2(COLS + 1);
    localparam int QYW = $clog2(ROWS + 1);

    state_t          state, state_nx;
    logic [N_CH-1:0] grant;
    logic [CW-1:0]   gidx;
    logic            any_req;
    logic            accept;

    logic [XW-1:0]   sel_x, sel_y;
    logic [3:0]      sel_dir;
    logic [SW-1:0]   off_x, off_y;

    logic [RW-1:0]   rem_x, rem_y;
    logic [QXW-1:0]  q_x;
    logic [QYW-1:0]  q_y;
    logic            neg_r;
    logic [CW-1:0]   ch_r;

    logic            rem_ok, at_edge, div_done, oob_now;
    logic [AW-1:0]   rd_addr;
    logic [3:0]      grid [NT];

    assign any_req   = |req_valid;
    assign accept    = (state == S_IDLE) && any_req && !rst;
    assign req_ready = accept ? grant : '0;
    assign rsp_valid = (state == S_RESP);

    maze_legal_move_engine_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant),
        .gidx   (gidx)
    );

    assign sel_x   = req_xpos[int'(gidx)*XW +: XW];
    assign sel_y   = req_ypos[int'(gidx)*XW +: XW];
    assign sel_dir = req_dir[int'(gidx)*4 +: 4];

    // Position relative to the grid origin after the heading look-ahead
    always_comb begin
        off_x = {2'b00, sel_x} - SW'(ORG_X);
        off_y = {2'b00, sel_y} - SW'(ORG_Y);
        case (sel_dir)
            HEAD_L:  off_x = off_x - SW'(LOOK_PX);
            HEAD_R:  off_x = off_x + SW'(LOOK_PX);
            HEAD_U:  off_y = off_y - SW'(LOOK_PX);
            HEAD_D:  off_y = off_y + SW'(LOOK_PX);
            default: ;
        endcase
    end

    // Division finishes once both remainders fit in a tile, or early
    // when either quotient runs off the grid edge.
    assign rem_ok   = (rem_x < RW'(TILE_W)) && (rem_y < RW'(TILE_W));
    assign at_edge  = (int'(q_x) == COLS) || (int'(q_y) == ROWS);
    assign div_done = neg_r || rem_ok || at_edge;
    assign oob_now  = neg_r || (int'(q_x) >= COLS) || (int'(q_y) >= ROWS);
    assign rd_addr  = AW'(int'(q_y) * COLS + int'(q_x));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (any_req) state_nx = S_DIV;
            S_DIV:   if (div_done) state_nx = S_LOOK;
            S_LOOK:  state_nx = S_RESP;
            S_RESP:  if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_x     <= '0;
            rem_y     <= '0;
            q_x       <= '0;
            q_y       <= '0;
            neg_r     <= 1'b0;
            ch_r      <= '0;
            rsp_ch    <= '0;
            rsp_moves <= 4'b0000;
            rsp_oob   <= 1'b0;
        end else begin
            if (accept) begin
                rem_x <= off_x[RW-1:0];
                rem_y <= off_y[RW-1:0];
                neg_r <= off_x[SW-1] | off_y[SW-1];
                q_x   <= '0;
                q_y   <= '0;
                ch_r  <= gidx;
            end
            if (state == S_DIV && !div_done) begin
                if (rem_x >= RW'(TILE_W)) begin
                    rem_x <= rem_x - RW'(TILE_W);
                    q_x   <= q_x + 1'b1;
                end
                if (rem_y >= RW'(TILE_W)) begin
                    rem_y <= rem_y - RW'(TILE_W);
                    q_y   <= q_y + 1'b1;
                end
            end
            // Read sees the grid before any same-edge cfg write
            if (state == S_LOOK) begin
                rsp_ch    <= ch_r;
                rsp_oob   <= oob_now;
                rsp_moves <= oob_now ? 4'b0000 : grid[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                grid[i] <= 4'b0000;
            end
        end else if (cfg_we && (int'(cfg_addr) < NT)) begin
            grid[cfg_addr] <= cfg_data;
        end
    end

endmodule
